// File: rtl/pwm_gen_multi_if.sv
// Bus bundle for pwm_gen_multi: configuration/load inputs and the PWM, sync and ack outputs.
// PWM_GEN_MULTI_CENTER_EN adds the center-mode select and a count-direction debug signal.
interface pwm_gen_multi_if #(
    parameter int CNT_W = 8,
    parameter int N_CH  = 4
);
    logic                  en;
    logic [CNT_W-1:0]      period;
    logic [N_CH*CNT_W-1:0] duty;
    logic                  load;
    logic                  load_ack;
    logic                  sync;
    logic [N_CH-1:0]       out;
`ifdef PWM_GEN_MULTI_CENTER_EN
    logic                  center;
    logic                  dbg_dir;

    modport master (output en, period, duty, load, center,
                    input  load_ack, sync, out, dbg_dir);
    modport slave  (input  en, period, duty, load, center,
                    output load_ack, sync, out, dbg_dir);
`else
    modport master (output en, period, duty, load,
                    input  load_ack, sync, out);
    modport slave  (input  en, period, duty, load,
                    output load_ack, sync, out);
`endif
endinterface

// File: rtl/pwm_gen_multi.sv
// N-channel PWM generator: one shared period counter, per-channel duty compare, shadowed settings.
// PWM_GEN_MULTI_CENTER_EN enables centre-aligned (up/down) counting selected per load.
module pwm_gen_multi #(
    parameter int CNT_W      = 8,
    parameter int N_CH       = 4,
    parameter int RST_PERIOD = 1,
    parameter int RST_DUTY   = 1
) (
    input  logic            clk,
    input  logic            rst,
    pwm_gen_multi_if.slave  bus_if
);
    // Handshake: load is a one-cycle strobe with no backpressure; load_ack pulses once
    // in the first cycle the captured values are active, however many loads preceded it.
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_P = CNT_W'(RST_PERIOD);
    localparam logic [CNT_W-1:0] RST_D = CNT_W'(RST_DUTY);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [CNT_W-1:0]            p_act_q, p_act_d, p_sh_q, p_sh_d;
    logic [N_CH-1:0][CNT_W-1:0]  d_act_q, d_act_d, d_sh_q, d_sh_d, duty_in;
    logic                        pend_q, pend_d;
    logic                        ack_q, ack_d;
    logic                        sync_q, sync_d;
    logic [N_CH-1:0]             out_q, out_d;
    logic                        wrap, boundary;

    assign duty_in = bus_if.duty;

`ifdef PWM_GEN_MULTI_CENTER_EN
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
    dir_e dir_q, dir_d;
    logic c_act_q, c_act_d, c_sh_q, c_sh_d;

    assign bus_if.dbg_dir = dir_q;

    // Up 0..P then down P-1..1; wrap is the last cycle before cnt returns to 0.
    always_comb begin
        dir_d = DIR_UP;
        cnt_d = '0;
        wrap  = 1'b0;
        if (c_act_q)
            wrap = (p_act_q == '0) ||
                   ((cnt_q == ONE) && ((dir_q == DIR_DOWN) || (p_act_q == ONE)));
        else
            wrap = (cnt_q == p_act_q);
        if (bus_if.en && !wrap) begin
            if (c_act_q && ((dir_q == DIR_DOWN) || (cnt_q == p_act_q))) begin
                cnt_d = cnt_q - ONE;
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end
`else
    always_comb begin
        wrap  = (cnt_q == p_act_q);
        cnt_d = '0;
        if (bus_if.en && !wrap) cnt_d = cnt_q + ONE;
    end
`endif

    // Idle counts as a boundary, so settings never change inside a running period.
    always_comb begin
        p_act_d  = p_act_q;
        d_act_d  = d_act_q;
        p_sh_d   = p_sh_q;
        d_sh_d   = d_sh_q;
        pend_d   = pend_q;
        ack_d    = 1'b0;
        boundary = !bus_if.en || wrap;
`ifdef PWM_GEN_MULTI_CENTER_EN
        c_act_d  = c_act_q;
        c_sh_d   = c_sh_q;
`endif
        if (bus_if.load && boundary) begin
            p_act_d = bus_if.period;
            d_act_d = duty_in;
            pend_d  = 1'b0;
            ack_d   = 1'b1;
`ifdef PWM_GEN_MULTI_CENTER_EN
            c_act_d = bus_if.center;
`endif
        end else if (pend_q && boundary) begin
            p_act_d = p_sh_q;
            d_act_d = d_sh_q;
            pend_d  = 1'b0;
            ack_d   = 1'b1;
`ifdef PWM_GEN_MULTI_CENTER_EN
            c_act_d = c_sh_q;
`endif
        end else if (bus_if.load) begin
            p_sh_d  = bus_if.period;
            d_sh_d  = duty_in;
            pend_d  = 1'b1;
`ifdef PWM_GEN_MULTI_CENTER_EN
            c_sh_d  = bus_if.center;
`endif
        end
    end

    always_comb begin
        out_d  = '0;
        sync_d = bus_if.en && (cnt_q == '0);
        for (int i = 0; i < N_CH; i++)
            out_d[i] = bus_if.en && (cnt_q < d_act_q[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            p_act_q <= RST_P;
            d_act_q <= {N_CH{RST_D}};
            p_sh_q  <= '0;
            d_sh_q  <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            sync_q  <= 1'b0;
            out_q   <= '0;
`ifdef PWM_GEN_MULTI_CENTER_EN
            dir_q   <= DIR_UP;
            c_act_q <= 1'b0;
            c_sh_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            p_act_q <= p_act_d;
            d_act_q <= d_act_d;
            p_sh_q  <= p_sh_d;
            d_sh_q  <= d_sh_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            sync_q  <= sync_d;
            out_q   <= out_d;
`ifdef PWM_GEN_MULTI_CENTER_EN
            dir_q   <= dir_d;
            c_act_q <= c_act_d;
            c_sh_q  <= c_sh_d;
`endif
        end
    end

    assign bus_if.out      = out_q;
    assign bus_if.sync     = sync_q;
    assign bus_if.load_ack = ack_q;
endmodule
